// File: rtl/mul_rr_scheduler_if.sv
// rtl/mul_rr_scheduler_if.sv - request/grant/writeback bundle of the multiplier scheduler
// grant_cnt exists only when MUL_SCHED_STATS_EN is defined.
interface mul_rr_scheduler_if #(
  parameter int NREQ  = 10,
  parameter int CNT_W = 16
);
  logic [NREQ-1:0]  req;
  logic             stall;
  logic [NREQ-1:0]  mul_en;
  logic [NREQ-1:0]  mul_read;
  logic             busy;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("mul_rr_scheduler_if: CNT_W must be >= 1");
  end

`ifdef MUL_SCHED_STATS_EN
  logic [CNT_W-1:0] grant_cnt;

  modport master (input req, stall, output mul_en, mul_read, busy, grant_cnt);
  modport slave  (output req, stall, input mul_en, mul_read, busy, grant_cnt);
`else
  modport master (input req, stall, output mul_en, mul_read, busy);
  modport slave  (output req, stall, input mul_en, mul_read, busy);
`endif
endinterface

// File: rtl/mul_rr_scheduler.sv
// rtl/mul_rr_scheduler.sv - round-robin grant of one LAT-cycle multiplier to NREQ registers
// MUL_SCHED_STATS_EN adds the saturating grant_cnt counter.
module mul_rr_scheduler #(
  parameter int NREQ  = 10,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  mul_rr_scheduler_if.master bus
);
  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || LAT < 1 || LAT > 8 || CNT_W < 1) begin : g_bad_param
    $error("mul_rr_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, RUN, STALL, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] mul_en_q, mul_en_d;
  logic [NREQ-1:0] mul_read_q, mul_read_d;
  logic [LAT-1:0]  pv_q, pv_d;
  logic [PW-1:0]   pidx_q [LAT];
  logic [PW-1:0]   pidx_d [LAT];

  logic [NREQ-1:0] eff;
  logic            found;
  logic [PW-1:0]   win;
  logic            grant;
  logic            pipe_empty;

  // Rotating priority search starting at ptr; the current grantee is masked out.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] cand;
    eff        = bus.req & ~mul_en_q;
    pipe_empty = (pv_q == '0);
    found      = 1'b0;
    win        = '0;
    sum        = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      cand = sum[PW-1:0];
      if (!found && eff[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    grant = found && !bus.stall && (state_q != STALL);
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    mul_en_d = '0;
    if (grant) begin
      mul_en_d[win] = 1'b1;
      ptr_d = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (found && !bus.stall) state_d = RUN;
        else if (found)          state_d = STALL;
      end
      RUN: begin
        if (bus.stall)   state_d = STALL;
        else if (!found) state_d = pipe_empty ? IDLE : DRAIN;
      end
      STALL: begin
        if (!bus.stall) begin
          if (found) state_d = RUN;
          else       state_d = pipe_empty ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (found && !bus.stall) state_d = RUN;
        else if (bus.stall)      state_d = STALL;
        else if (pipe_empty)     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pipeline shifts every cycle; mul_read is registered off the last stage.
    pv_d[0]   = grant;
    pidx_d[0] = win;
    for (int i = 1; i < LAT; i++) begin
      pv_d[i]   = pv_q[i-1];
      pidx_d[i] = pidx_q[i-1];
    end
    mul_read_d = '0;
    if (pv_q[LAT-1]) mul_read_d[pidx_q[LAT-1]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      mul_en_q   <= '0;
      mul_read_q <= '0;
      pv_q       <= '0;
      for (int i = 0; i < LAT; i++) pidx_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mul_en_q   <= mul_en_d;
      mul_read_q <= mul_read_d;
      pv_q       <= pv_d;
      pidx_q     <= pidx_d;
    end
  end

  assign bus.mul_en   = mul_en_q;
  assign bus.mul_read = mul_read_q;
  assign bus.busy     = (state_q != IDLE) || (pv_q != '0);

`ifdef MUL_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bus.grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_mul_rr_scheduler.sv
// tb/tb_mul_rr_scheduler.sv - directed and random checks of mul_rr_scheduler at LAT=1 and LAT=3
module tb_mul_rr_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] req;
  logic       stall;
  int         errors = 0;
  int         checks = 0;

  mul_rr_scheduler_if #(.NREQ(10), .CNT_W(16)) ifa ();
  mul_rr_scheduler_if #(.NREQ(10), .CNT_W(16)) ifb ();

  assign ifa.req = req;
  assign ifa.stall = stall;
  assign ifb.req = req;
  assign ifb.stall = stall;

  mul_rr_scheduler #(.NREQ(10), .LAT(1), .CNT_W(16)) u_a (.clk(clk), .reset(reset), .bus(ifa));
  mul_rr_scheduler #(.NREQ(10), .LAT(3), .CNT_W(16)) u_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;

  localparam int S_IDLE = 0, S_RUN = 1, S_STALL = 2, S_DRAIN = 3;
  int lat [2] = '{1, 3};
  int m_state [2];
  int m_ptr [2];
  int m_cnt [2];
  int hist [2][10];   // hist[x][k]: register granted k cycles ago, -1 for none

  function automatic logic [9:0] oh(input int i);
    logic [9:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int x, input logic rst, input logic [9:0] rq, input logic st);
    logic [9:0] eff;
    bit empty;
    int win, g;
    if (rst) begin
      m_state[x] = S_IDLE;
      m_ptr[x] = 0;
      m_cnt[x] = 0;
      for (int k = 0; k < 10; k++) hist[x][k] = -1;
      return;
    end
    eff = rq & ~oh(hist[x][0]);
    empty = 1;
    for (int k = 0; k < lat[x]; k++) if (hist[x][k] >= 0) empty = 0;
    win = -1;
    for (int k = 0; k < 10; k++)
      if (win < 0 && eff[(m_ptr[x] + k) % 10]) win = (m_ptr[x] + k) % 10;
    g = (m_state[x] != S_STALL && !st) ? win : -1;
    case (m_state[x])
      S_IDLE:  if (win >= 0) m_state[x] = st ? S_STALL : S_RUN;
      S_RUN:   if (st) m_state[x] = S_STALL;
               else if (win < 0) m_state[x] = empty ? S_IDLE : S_DRAIN;
      S_STALL: if (!st) m_state[x] = (win >= 0) ? S_RUN : (empty ? S_IDLE : S_DRAIN);
      default: if (win >= 0 && !st) m_state[x] = S_RUN;
               else if (st) m_state[x] = S_STALL;
               else if (empty) m_state[x] = S_IDLE;
    endcase
    for (int k = 9; k > 0; k--) hist[x][k] = hist[x][k-1];
    hist[x][0] = g;
    if (g >= 0) begin
      m_ptr[x] = (g + 1) % 10;
      if (m_cnt[x] < 65535) m_cnt[x]++;
    end
  endtask

  function automatic bit m_busy(input int x);
    bit b;
    b = (m_state[x] != S_IDLE);
    for (int k = 0; k < lat[x]; k++) if (hist[x][k] >= 0) b = 1;
    return b;
  endfunction

  task automatic step(input logic rst, input logic [9:0] rq, input logic st);
    reset = rst;
    req = rq;
    stall = st;
    model_step(0, rst, rq, st);
    model_step(1, rst, rq, st);
    @(posedge clk);
    #1;
    chk("a_mul_en",   32'(ifa.mul_en),   32'(oh(hist[0][0])));
    chk("a_mul_read", 32'(ifa.mul_read), 32'(oh(hist[0][1])));
    chk("a_busy",     32'(ifa.busy),     32'(m_busy(0)));
    chk("b_mul_en",   32'(ifb.mul_en),   32'(oh(hist[1][0])));
    chk("b_mul_read", 32'(ifb.mul_read), 32'(oh(hist[1][3])));
    chk("b_busy",     32'(ifb.busy),     32'(m_busy(1)));
`ifdef MUL_SCHED_STATS_EN
    chk("a_grant_cnt", 32'(ifa.grant_cnt), 32'(m_cnt[0]));
    chk("b_grant_cnt", 32'(ifb.grant_cnt), 32'(m_cnt[1]));
`endif
  endtask

  initial begin
    // reset held with all requests pending
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 10'h3FF, 1'b0);
      chk("rst_en", 32'(ifa.mul_en), 32'h0);
      chk("rst_busy", 32'(ifb.busy), 32'h0);
    end

    // two requesters alternate
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 10'b0000010001, 1'b0);
      chk("alt_en", 32'(ifa.mul_en), (i % 2 == 0) ? 32'h001 : 32'h010);
    end

    // grant 8 sets ptr=9, then 9 wraps ptr to 0
    step(1'b0, 10'h100, 1'b0);
    chk("wrap_8", 32'(ifa.mul_en), 32'h100);
    step(1'b0, 10'h201, 1'b0);
    chk("wrap_9", 32'(ifa.mul_en), 32'h200);
    step(1'b0, 10'h201, 1'b0);
    chk("wrap_0", 32'(ifa.mul_en), 32'h001);
    step(1'b0, 10'h201, 1'b0);
    chk("wrap_9b", 32'(ifa.mul_en), 32'h200);

    // stall in the middle of a full-request stream
    for (int i = 0; i < 4; i++) step(1'b0, 10'h3FF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 10'h3FF, 1'b1);
      chk("stall_en", 32'(ifa.mul_en), 32'h0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 10'h3FF, 1'b0);

    // LAT=3 single grant to register 4, then drain
    step(1'b1, 10'h000, 1'b0);
    step(1'b0, 10'h010, 1'b0);
    chk("l3_grant", 32'(ifb.mul_en), 32'h010);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 10'h000, 1'b0);
      chk("l3_read", 32'(ifb.mul_read), (k == 3) ? 32'h010 : 32'h0);
      chk("l3_busy", 32'(ifb.busy), (k == 4) ? 32'h0 : 32'h1);
    end

    // 25 grants then a mid-stream reset
    step(1'b1, 10'h000, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, 10'h3FF, 1'b0);
`ifdef MUL_SCHED_STATS_EN
    chk("cnt_25", 32'(ifa.grant_cnt), 32'd25);
`endif
    step(1'b1, 10'h3FF, 1'b0);
`ifdef MUL_SCHED_STATS_EN
    chk("cnt_clr", 32'(ifa.grant_cnt), 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 10'h000, 1'b0);
      chk("post_rst_read", 32'(ifb.mul_read), 32'h0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [9:0] rq;
      rq = 10'($urandom);
      if ($urandom_range(0, 5) == 0) rq = '0;
      step($urandom_range(0, 49) == 0, rq, $urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
